vga_timing_gen: RTL

Parametrised VGA raster timing generator and pixel output stage, the next generation of the fixed 640x480 sync block on the baseboard. Produces sync, data-enable and pixel coordinates for any mode set by parameters, gates the pixel clock through a clock enable, and re-aligns sync to a client pixel source with a fixed, known latency. Built-in test patterns can drive the display without a client. Sits between the pixel generator (or nothing) and the board VGA resistor DAC pins.

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing, test patterns and latency-matched pixel output
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 1,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2
) (
  input  logic                     app_clk,
  input  logic                     app_rst,
  input  logic                     pix_ce,
  input  logic [1:0]               mode,
  output logic [11:0]              pos_x,
  output logic [11:0]              pos_y,
  output logic                     pos_de,
  input  logic [R_W+G_W+B_W-1:0]   pix_in,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic [R_W-1:0]           red,
  output logic [G_W-1:0]           green,
  output logic [B_W-1:0]           blue,
  output logic                     frame_start,
  output logic                     line_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = R_W + G_W + B_W;
  localparam int DW      = PW + 5;
  localparam int BAR_W   = H_ACTIVE / 8;
  logic [11:0] r_h_cnt, r_v_cnt, r_bar_cnt;
  logic [2:0]  r_bar_k;
  logic [1:0]  r_mode;
  logic        r_hs, r_vs, r_fs, r_ls;
  logic        w_h_last, w_v_last, w_o_de;
  logic [PW-1:0] w_pat, w_rgb;
  logic [PIX_LAT:0][DW-1:0] w_dl;
  logic [DW-1:0] w_o;
  assign w_h_last = r_h_cnt == 12'(H_TOTAL - 1);
  assign w_v_last = r_v_cnt == 12'(V_TOTAL - 1);
  // raster counters, bar tracker aligned with pos_x, and per-frame mode latch
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_cnt <= '0;
      r_bar_k   <= '0;
      r_mode    <= '0;
    end else if (pix_ce) begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + 12'd1;
      if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + 12'd1;
      r_bar_cnt <= (r_h_cnt == '0 || r_bar_cnt == 12'(BAR_W - 1)) ? '0 : r_bar_cnt + 12'd1;
      r_bar_k   <= (r_h_cnt == '0) ? '0 : (r_bar_cnt == 12'(BAR_W - 1)) ? r_bar_k + 3'd1 : r_bar_k;
      if (r_h_cnt == '0 && r_v_cnt == '0) r_mode <= mode;
    end
  end
  // S1: requested position plus raw active-high sync and line/frame flags
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      pos_x  <= '0;
      pos_y  <= '0;
      pos_de <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_fs   <= 1'b0;
      r_ls   <= 1'b0;
    end else if (pix_ce) begin
      pos_x  <= r_h_cnt;
      pos_y  <= r_v_cnt;
      pos_de <= r_h_cnt < 12'(H_ACTIVE) && r_v_cnt < 12'(V_ACTIVE);
      r_hs   <= r_h_cnt >= 12'(H_ACTIVE + H_FP) && r_h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC);
      r_vs   <= r_v_cnt >= 12'(V_ACTIVE + V_FP) && r_v_cnt < 12'(V_ACTIVE + V_FP + V_SYNC);
      r_fs   <= r_h_cnt == '0 && r_v_cnt == '0;
      r_ls   <= r_h_cnt == '0;
    end
  end
  // built-in pattern for the S1 position
  always_comb
    w_pat = (r_mode == 2'd1) ? {{R_W{~r_bar_k[1]}}, {G_W{~r_bar_k[2]}}, {B_W{~r_bar_k[0]}}} :
            (r_mode == 2'd2) ? {PW{pos_x[3] ^ pos_y[3]}} :
                               {PW{pos_x[3:0] == 4'd0 || pos_y[3:0] == 4'd0}};
  assign w_dl[0] = {r_hs, r_vs, pos_de, r_fs, r_ls, w_pat};
  for (genvar i = 0; i < PIX_LAT; i++) begin : g_dl
    logic [DW-1:0] r_s;
    // one ce-stage of the client-latency matching delay line
    always_ff @(posedge app_clk) begin
      if (app_rst) r_s <= '0;
      else if (pix_ce) r_s <= w_dl[i];
    end
    assign w_dl[i+1] = r_s;
  end
  assign w_o    = w_dl[PIX_LAT];
  assign w_o_de = w_o[PW+2];
  assign w_rgb  = w_o_de ? ((r_mode == 2'd0) ? pix_in : w_o[PW-1:0]) : '0;
  // output register: source select, blanking and sync polarity
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      hsync               <= ~HS_POL;
      vsync               <= ~VS_POL;
      de                  <= 1'b0;
      frame_start         <= 1'b0;
      line_start          <= 1'b0;
      {red, green, blue}  <= '0;
    end else if (pix_ce) begin
      hsync               <= w_o[PW+4] ? HS_POL : ~HS_POL;
      vsync               <= w_o[PW+3] ? VS_POL : ~VS_POL;
      de                  <= w_o_de;
      frame_start         <= w_o[PW+1];
      line_start          <= w_o[PW];
      {red, green, blue}  <= w_rgb;
    end
  end
endmodule
